// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcodes, FSM states and
// condition-code bit positions, plus a helper that packs the ZCNV flags.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_PASSA = 4'd5,
    OP_MUL   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_SHLN  = 4'd8,
    OP_LSHRN = 4'd9,
    OP_ASHRN = 4'd10
  } alu_mc_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } alu_mc_state_t;

  localparam int Z_BIT = 3;
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;

  function automatic logic [3:0] mk_cc(input logic z, input logic c,
                                       input logic n, input logic v);
    logic [3:0] cc;
    cc        = '0;
    cc[Z_BIT] = z;
    cc[C_BIT] = c;
    cc[N_BIT] = n;
    cc[V_BIT] = v;
    return cc;
  endfunction

endpackage

// File: rtl/alu_mc_step.sv
// One iteration of the multi-cycle datapath: shift-add multiply step, restoring
// divide step, or a single-bit shift of the working register mq.
module alu_mc_step
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_mc_op_t       op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o,
  output logic             c_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_o = acc_i;
    mq_o  = mq_i;
    c_o   = 1'b0;
    sum   = {1'b0, acc_i} + {1'b0, b_i};
    r_sh  = {acc_i, mq_i[WIDTH-1]};
    diff  = r_sh - {1'b0, b_i};
    case (op_i)
      // {acc,mq} is the double-width product; multiplier bits retire from mq[0]
      OP_MUL: begin
        if (mq_i[0]) {acc_o, mq_o} = {sum, mq_i[WIDTH-1:1]};
        else         {acc_o, mq_o} = {1'b0, acc_i, mq_i[WIDTH-1:1]};
      end
      // acc holds the partial remainder; quotient bits shift into mq[0]
      OP_DIVU: begin
        if (!diff[WIDTH]) begin
          acc_o = diff[WIDTH-1:0];
          mq_o  = {mq_i[WIDTH-2:0], 1'b1};
        end else begin
          acc_o = r_sh[WIDTH-1:0];
          mq_o  = {mq_i[WIDTH-2:0], 1'b0};
        end
      end
      OP_SHLN: begin
        c_o  = mq_i[WIDTH-1];
        mq_o = {mq_i[WIDTH-2:0], 1'b0};
      end
      OP_LSHRN: begin
        c_o  = mq_i[0];
        mq_o = {1'b0, mq_i[WIDTH-1:1]};
      end
      OP_ASHRN: begin
        c_o  = mq_i[0];
        mq_o = {mq_i[WIDTH-1], mq_i[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-step ops finish in one cycle, MUL/DIVU/shifts iterate
// through alu_mc_step; results and ZCNV are registered on the done edge.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  alu_mc_op_t       opcode,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       condCodes
);

  localparam logic [SHW:0] CNT_ONE  = 1;
  localparam logic [SHW:0] CNT_FULL = WIDTH[SHW:0];

  alu_mc_state_t    state_q, state_d;
  alu_mc_op_t       op_q, op_d, op_eff;
  logic [SHW:0]     cnt_q, cnt_d, iter;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic [3:0]       cc_q, cc_d;

  logic [WIDTH-1:0] acc_nx, mq_nx;
  logic             c_nx;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [WIDTH-1:0] res1, hi1;
  logic             c1, v1, is_shift, multi, c_fin;

  alu_mc_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .mq_i  (mq_q),
    .b_i   (b_q),
    .acc_o (acc_nx),
    .mq_o  (mq_nx),
    .c_o   (c_nx)
  );

  // Decode and single-step results, computed straight from the input operands
  always_comb begin
    op_eff   = (opcode > OP_ASHRN) ? OP_PASSA : opcode;
    is_shift = (op_eff == OP_SHLN) || (op_eff == OP_LSHRN) || (op_eff == OP_ASHRN);
    multi    = (op_eff == OP_MUL) || ((op_eff == OP_DIVU) && (inB != '0)) ||
               (is_shift && (inB[SHW-1:0] != '0));
    iter     = ((op_eff == OP_MUL) || (op_eff == OP_DIVU)) ? CNT_FULL
                                                           : {1'b0, inB[SHW-1:0]};
    sum_ext  = {1'b0, inA} + {1'b0, inB};
    dif_ext  = {1'b0, inA} - {1'b0, inB};
    res1     = inA;
    hi1      = '0;
    c1       = 1'b0;
    v1       = 1'b0;
    case (op_eff)
      OP_ADD: begin
        res1 = sum_ext[WIDTH-1:0];
        c1   = sum_ext[WIDTH];
        v1   = (inA[WIDTH-1] == inB[WIDTH-1]) && (res1[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_SUB: begin
        res1 = dif_ext[WIDTH-1:0];
        c1   = dif_ext[WIDTH];
        v1   = (inA[WIDTH-1] != inB[WIDTH-1]) && (res1[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_AND: res1 = inA & inB;
      OP_OR:  res1 = inA | inB;
      OP_XOR: res1 = inA ^ inB;
      OP_DIVU: begin
        res1 = '1;
        hi1  = inA;
        c1   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    b_d      = b_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    cc_d     = cc_q;
    c_fin    = (op_q == OP_MUL) ? (acc_nx != '0) : (op_q == OP_DIVU) ? 1'b0 : c_nx;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op_eff;
          b_d   = inB;
          mq_d  = inA;
          acc_d = '0;
          cnt_d = iter;
          if (multi) begin
            state_d = RUN;
          end else begin
            state_d  = FIN;
            out_d    = res1;
            out_hi_d = hi1;
            cc_d     = mk_cc(res1 == '0, c1, res1[WIDTH-1], v1);
          end
        end
      end
      RUN: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = FIN;
          out_d    = mq_nx;
          out_hi_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? acc_nx : '0;
          cc_d     = mk_cc(mq_nx == '0, c_fin, mq_nx[WIDTH-1], 1'b0);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      op_q     <= OP_PASSA;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      b_q      <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      b_q      <= b_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      cc_q     <= cc_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign condCodes = cc_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed cases plus random ops
// compared against an arithmetic reference model of each operation.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clock = 1'b0;
  logic        reset_L, start;
  alu_mc_op_t  opcode;
  logic [15:0] inA, inB;
  logic        busy, done;
  logic [15:0] out, out_hi;
  logic [3:0]  condCodes;

  int vectors     = 0;
  int n_checks    = 0;
  int miscompares = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .start     (start),
    .opcode    (opcode),
    .inA       (inA),
    .inB       (inB),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .out_hi    (out_hi),
    .condCodes (condCodes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic on the operands
  function automatic void model(input alu_mc_op_t op, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] o,
                                output logic [15:0] oh, output logic [3:0] cc,
                                output int lat);
    logic [31:0] p;
    logic [16:0] s;
    logic        c, v;
    int          n, si;
    n = int'(b[3:0]);
    c = 1'b0; v = 1'b0; oh = '0; lat = 1; o = a;
    case (op)
      OP_ADD: begin
        s = a + b; o = s[15:0]; c = s[16];
        si = $signed(a) + $signed(b); v = (si > 32767) || (si < -32768);
      end
      OP_SUB: begin
        o = a - b; c = (b > a);
        si = $signed(a) - $signed(b); v = (si > 32767) || (si < -32768);
      end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_MUL: begin
        p = a * b; o = p[15:0]; oh = p[31:16]; c = (oh != 0); lat = 17;
      end
      OP_DIVU: begin
        if (b == 0) begin o = 16'hFFFF; oh = a; c = 1'b1; end
        else begin o = a / b; oh = a % b; lat = 17; end
      end
      OP_SHLN:  begin o = a << n; c = (n > 0) ? a[16-n] : 1'b0; lat = n + 1; end
      OP_LSHRN: begin o = a >> n; c = (n > 0) ? a[n-1] : 1'b0; lat = n + 1; end
      OP_ASHRN: begin o = $signed(a) >>> n; c = (n > 0) ? a[n-1] : 1'b0; lat = n + 1; end
      default: o = a;
    endcase
    cc = {o == 0, c, o[15], v};
  endfunction

  // Issue one op; optionally pulse start or drop reset_L in cycle pulse_at/rst_at
  task automatic run_op(input alu_mc_op_t op, input logic [15:0] a, input logic [15:0] b,
                        input int pulse_at, input int rst_at);
    logic [15:0] eo, eoh;
    logic [3:0]  ecc;
    int          elat, lat;
    logic [15:0] go, goh;
    logic [3:0]  gcc;
    vectors++;
    model(op, a, b, eo, eoh, ecc, elat);
    if (rst_at > 0) begin elat = 0; eo = '0; eoh = '0; ecc = '0; end
    @(negedge clock);
    start = 1'b1; opcode = op; inA = a; inB = b;
    @(negedge clock);
    start = 1'b0; inA = 16'($urandom); inB = 16'($urandom);
    lat = 0; go = '0; goh = '0; gcc = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 1) chk("busy_c1", 32'(busy), 32'd1);
      if (rst_at > 0 && k == rst_at + 1) chk("busy_after_rst", 32'(busy), 32'd0);
      if (done && lat == 0) begin lat = k; go = out; goh = out_hi; gcc = condCodes; end
      start   = (k == pulse_at);
      if (k == pulse_at) begin opcode = OP_ADD; inA = 16'h1111; inB = 16'h2222; end
      reset_L = !(k == rst_at);
      if (lat != 0) break;
    end
    start = 1'b0; reset_L = 1'b1;
    if (rst_at > 0) begin go = out; goh = out_hi; gcc = condCodes; end
    chk("latency", 32'(lat), 32'(elat));
    chk("out", 32'(go), 32'(eo));
    chk("out_hi", 32'(goh), 32'(eoh));
    chk("zcnv", 32'(gcc), 32'(ecc));
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    $display("op=%0d A=%h B=%h -> out=%h hi=%h zcnv=%b lat=%0d", int'(op), a, b,
             go, goh, gcc, lat);
  endtask

  initial begin
    reset_L = 1'b0; start = 1'b0; opcode = OP_ADD; inA = '0; inB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_hi", 32'(out_hi), 32'd0);
    chk("rst_cc", 32'(condCodes), 32'd0);
    reset_L = 1'b1;

    run_op(OP_ADD,   16'h7FFF, 16'h0001, 0, 0);
    run_op(OP_SUB,   16'h0003, 16'h0005, 0, 0);
    run_op(OP_SUB,   16'h1234, 16'h1234, 0, 0);
    run_op(OP_MUL,   16'h1234, 16'h0100, 5, 0);
    run_op(OP_DIVU,  16'd100,  16'd7,    0, 0);
    run_op(OP_DIVU,  16'h0005, 16'h0000, 0, 0);
    run_op(OP_ASHRN, 16'h8001, 16'd3,    0, 0);
    run_op(OP_SHLN,  16'h8000, 16'd1,    0, 0);
    run_op(OP_LSHRN, 16'hA5C3, 16'h0010, 0, 0);
    run_op(OP_LSHRN, 16'hA5C3, 16'd15,   0, 0);
    run_op(OP_MUL,   16'hFFFF, 16'hFFFF, 0, 0);
    run_op(OP_MUL,   16'h1234, 16'h5678, 0, 5);
    run_op(OP_ADD,   16'h0001, 16'h0001, 0, 0);
    run_op(alu_mc_op_t'(4'd13), 16'hBEEF, 16'h1234, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      alu_mc_op_t  rop;
      rop = alu_mc_op_t'(4'($urandom_range(0, 12)));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
      run_op(rop, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
